// File: rtl/fifo_pkg.sv
// Shared FIFO package.
// Holds the read-side output buffer depth and the occupancy type that the
// read streamer and its skid buffer share.
package fifo_pkg;

  // Occupancy of the read-side output buffer (0..2).
  typedef logic [1:0] rd_occ_t;

  // Depth of the read-side output buffer.
  localparam rd_occ_t RD_BUF_DEPTH = 2'd2;

endpackage

// File: rtl/fifo_rd_skid_buf.sv
// Two-entry skid buffer used on the FIFO read side.
// Ports:
//   clk, rst_n        - clock, synchronous active-low reset
//   clr               - synchronous clear of occupancy and pointers
//   push, push_data   - write one word at the tail
//   pop               - drop the word at the head
//   pop_data          - oldest buffered word
//   occ               - number of buffered words (0..2)
// The caller guarantees no push when full and no pop when empty.
module fifo_rd_skid_buf
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] pop_data,
  output rd_occ_t               occ
);

  logic [DATA_WIDTH-1:0] mem_q [0:1];
  logic [DATA_WIDTH-1:0] mem_d [0:1];
  logic                  head_q, head_d;
  logic                  tail_q, tail_d;
  rd_occ_t               occ_q, occ_d;

  always_comb begin
    mem_d  = mem_q;
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    if (clr) begin
      head_d = '0;
      tail_d = '0;
      occ_d  = '0;
    end else begin
      if (push) begin
        mem_d[tail_q] = push_data;
        tail_d        = ~tail_q;
      end
      if (pop) begin
        head_d = ~head_q;
      end
      occ_d = occ_q + rd_occ_t'(push) - rd_occ_t'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q  <= '{default: '0};
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

  assign pop_data = mem_q[head_q];
  assign occ      = occ_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// FIFO read-side streamer: pops a FIFO with one-cycle read latency and
// presents the words on a valid/ready stream through a 2-entry buffer,
// sustaining one word per cycle.
// Ports:
//   rd_clk, rd_rst_n  - clock, synchronous active-low reset
//   flush             - drop buffered and in-flight words
//   fifo_empty        - FIFO empty flag
//   fifo_rd_en        - FIFO pop request
//   fifo_rd_data      - FIFO data, valid one cycle after an accepted pop
//   out_valid/out_ready/out_data - output stream
//   word_cnt, stall_cnt - statistics, present only with FIFO_RD_STAT_EN
// Optional feature macro: FIFO_RD_STAT_EN (statistics counters).
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 4,
  parameter int unsigned STAT_WIDTH = 16
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst_n,
  input  logic                  flush,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data
`ifdef FIFO_RD_STAT_EN
  ,
  output logic [STAT_WIDTH-1:0] word_cnt,
  output logic [STAT_WIDTH-1:0] stall_cnt
`endif
);

  logic    inflight_q, inflight_d;
  rd_occ_t occ;
  rd_occ_t fill_lvl;
  logic    xfer;
  logic    push;

  // Buffered plus in-flight words; the pop rule keeps this at or below 2.
  assign fill_lvl = occ + rd_occ_t'(inflight_q);

  always_comb begin
    out_valid  = (occ != '0);
    xfer       = out_valid && out_ready && !flush;
    push       = inflight_q && !flush;
    // A transfer this cycle frees a slot in time for the word popped now.
    fifo_rd_en = rd_rst_n && !fifo_empty && !flush &&
                 ((fill_lvl < RD_BUF_DEPTH) || (out_valid && out_ready));
    inflight_d = fifo_rd_en;
  end

  always_ff @(posedge rd_clk) begin
    if (!rd_rst_n) begin
      inflight_q <= '0;
    end else begin
      inflight_q <= inflight_d;
    end
  end

  fifo_rd_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_buf (
    .clk       (rd_clk),
    .rst_n     (rd_rst_n),
    .clr       (flush),
    .push      (push),
    .push_data (fifo_rd_data),
    .pop       (xfer),
    .pop_data  (out_data),
    .occ       (occ)
  );

`ifdef FIFO_RD_STAT_EN
  logic [STAT_WIDTH-1:0] word_cnt_q, word_cnt_d;
  logic [STAT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    word_cnt_d  = word_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (flush) begin
      word_cnt_d  = '0;
      stall_cnt_d = '0;
    end else begin
      if (xfer && (word_cnt_q != '1)) begin
        word_cnt_d = word_cnt_q + 1'b1;
      end
      if (out_valid && !out_ready && (stall_cnt_q != '1)) begin
        stall_cnt_d = stall_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge rd_clk) begin
    if (!rd_rst_n) begin
      word_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      word_cnt_q  <= word_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign word_cnt  = word_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Scoreboard bench for fifo_rd_stream. The driver models the FIFO source and
// keeps a queue of words expected on the output (plus one in-flight word);
// a monitor process compares the DUT against that queue every cycle.
// With FIFO_RD_STAT_EN a second instance with STAT_WIDTH=2 checks saturation.
module tb_fifo_rd_stream;

  localparam int unsigned DW = 8;
  localparam int unsigned SW = 16;

  logic          rd_clk = 1'b0;
  logic          rd_rst_n;
  logic          flush;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_rd_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
`ifdef FIFO_RD_STAT_EN
  logic [SW-1:0] word_cnt, stall_cnt;
  logic [1:0]    word_cnt2, stall_cnt2;
  logic          fifo_rd_en2, out_valid2;
  logic [DW-1:0] out_data2;
`endif

  always #5 rd_clk = ~rd_clk;

  fifo_rd_stream #(
    .DATA_WIDTH (DW),
    .STAT_WIDTH (SW)
  ) dut (
    .rd_clk       (rd_clk),
    .rd_rst_n     (rd_rst_n),
    .flush        (flush),
    .fifo_empty   (fifo_empty),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_data (fifo_rd_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data)
`ifdef FIFO_RD_STAT_EN
    ,
    .word_cnt     (word_cnt),
    .stall_cnt    (stall_cnt)
`endif
  );

`ifdef FIFO_RD_STAT_EN
  fifo_rd_stream #(
    .DATA_WIDTH (DW),
    .STAT_WIDTH (2)
  ) dut_sat (
    .rd_clk       (rd_clk),
    .rd_rst_n     (rd_rst_n),
    .flush        (flush),
    .fifo_empty   (fifo_empty),
    .fifo_rd_en   (fifo_rd_en2),
    .fifo_rd_data (fifo_rd_data),
    .out_valid    (out_valid2),
    .out_ready    (out_ready),
    .out_data     (out_data2),
    .word_cnt     (word_cnt2),
    .stall_cnt    (stall_cnt2)
  );
`endif

  // Reference model state
  logic [DW-1:0] exp_q [$];
  bit            inf_vld = 1'b0;
  logic [DW-1:0] inf_word = '0;
  logic [DW-1:0] src_next = 8'h01;
  int            src_left = 0;
  bit            prev_rst = 1'b0;
  bit            cyc_valid = 1'b0;
  int            words_model = 0;
  int            stalls_model = 0;
  int            n_chk = 0;
  int            n_pass = 0;
  event          chk_ev;

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: compares DUT outputs with the scoreboard, pops on transfer.
  initial begin
    forever begin
      logic exp_en;
      bit   mv;
      @(chk_ev);
      mv     = (exp_q.size() > 0);
      exp_en = rd_rst_n && !fifo_empty && !flush &&
               (((exp_q.size() + int'(inf_vld)) < 2) || (mv && out_ready));
      check("fifo_rd_en", fifo_rd_en, exp_en);
      check("out_valid", out_valid, mv);
      if (mv) check("out_data", out_data, exp_q[0]);
      if (prev_rst) check("out_data_after_reset", out_data, '0);
`ifdef FIFO_RD_STAT_EN
      check("word_cnt", word_cnt, sat(words_model, (1 << SW) - 1));
      check("stall_cnt", stall_cnt, sat(stalls_model, (1 << SW) - 1));
      check("word_cnt_sat", word_cnt2, sat(words_model, 3));
      check("stall_cnt_sat", stall_cnt2, sat(stalls_model, 3));
      check("sat_fifo_rd_en", fifo_rd_en2, exp_en);
      check("sat_out_valid", out_valid2, mv);
      if (mv) check("sat_out_data", out_data2, exp_q[0]);
`endif
      if (mv && out_ready && !flush && rd_rst_n) void'(exp_q.pop_front());
    end
  end

  // One clock cycle of stimulus plus the model update for the coming edge.
  task automatic step(input bit rst_n, input bit emp, input bit rdy, input bit fl);
    @(negedge rd_clk);
    rd_rst_n     = rst_n;
    flush        = fl;
    out_ready    = rdy;
    fifo_empty   = emp || (src_left <= 0);
    fifo_rd_data = inf_vld ? inf_word : DW'($urandom);
    #1;
    cyc_valid = (exp_q.size() > 0);
    -> chk_ev;
    #1;
    if (!rd_rst_n || flush) begin
      exp_q.delete();
      inf_vld      = 1'b0;
      words_model  = 0;
      stalls_model = 0;
    end else begin
      if (cyc_valid && out_ready)  words_model++;
      if (cyc_valid && !out_ready) stalls_model++;
      if (inf_vld) begin
        exp_q.push_back(inf_word);
        inf_vld = 1'b0;
      end
      if (fifo_rd_en && !fifo_empty) begin
        inf_vld  = 1'b1;
        inf_word = src_next;
        src_next = src_next + 1'b1;
        src_left--;
      end
    end
    prev_rst = !rd_rst_n;
  endtask

  initial begin
    rd_rst_n     = 1'b0;
    flush        = 1'b0;
    fifo_empty   = 1'b1;
    out_ready    = 1'b0;
    fifo_rd_data = '0;

    repeat (3) step(0, 0, 1, 0);

    // streaming: exactly 8 source words 0x1..0x8
    src_left = 8;
    repeat (12) step(1, 0, 1, 0);

    // backpressure then release
    src_left = 1_000_000;
    repeat (4) step(1, 0, 1, 0);
    repeat (5) step(1, 0, 0, 0);
    repeat (4) step(1, 0, 1, 0);

    // empty FIFO: buffer drains
    repeat (6) step(1, 1, 1, 0);

    // flush with a full buffer
    repeat (4) step(1, 0, 0, 0);
    step(1, 0, 0, 1);
    repeat (3) step(1, 0, 1, 0);

    // flush with one buffered and one in-flight word
    repeat (4) step(1, 1, 1, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 1);
    repeat (4) step(1, 0, 1, 0);

    // reset mid-stream
    repeat (4) step(1, 0, 1, 0);
    step(0, 0, 1, 0);
    repeat (6) step(1, 0, 1, 0);

    // randomized traffic
    repeat (600) begin
      step($urandom_range(0, 49) != 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0);
    end

    #10;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
